fpu_addsub_arbiter: RTL and testbench

- Shares one fixed-latency, non-stallable FP add/sub pipeline unit among NREQ requesters.
- The unit carries only a flag and a 5-bit address tag, so this block does four jobs: round-robin issue arbitration; driving the unit's input registers; tracking which requester owns each in-flight operation; routing each returning result to a registered writeback port, tagged with its source.
- Sits between the issue logic and the FPU add/sub unit.

---
 rtl/fpu_addsub_arbiter_if.sv | 14 +
 rtl/fpu_addsub_arbiter.sv | 108 ++++++++++
 tb/tb_fpu_addsub_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fpu_addsub_arbiter_if.sv
// fpu_addsub_arbiter_if: requester-side issue bus shared by NREQ requesters
interface fpu_addsub_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW = 5
);
  logic [NREQ-1:0] req_valid;
  logic [NREQ-1:0] req_ready;
  logic [32*NREQ-1:0] req_adata;
  logic [32*NREQ-1:0] req_bdata;
  logic [AW*NREQ-1:0] req_addr;
  logic hold;
  modport master (output req_valid, req_adata, req_bdata, req_addr, hold, input req_ready);
  modport slave (input req_valid, req_adata, req_bdata, req_addr, hold, output req_ready);
endinterface

// File: rtl/fpu_addsub_arbiter.sv
// fpu_addsub_arbiter: round-robin issue into a shared fixed-latency FP add/sub unit with owner-tagged writeback
module fpu_addsub_arbiter #(
  parameter int NREQ = 2,
  parameter int LAT = 3,
  parameter int AW = 5,
  localparam int IW = NREQ > 2 ? $clog2(NREQ) : 1,
  localparam int GW = $clog2(LAT + 1)
) (
  input  logic clk,
  input  logic rst,
  fpu_addsub_arbiter_if.slave req,
  output logic [31:0] fu_adata,
  output logic [31:0] fu_bdata,
  output logic fu_flag,
  output logic [AW-1:0] fu_address,
  input  logic fu_flag_out,
  input  logic [AW-1:0] fu_address_out,
  input  logic [31:0] fu_result,
  output logic wb_valid,
  output logic [AW-1:0] wb_addr,
  output logic [31:0] wb_data,
  output logic [IW-1:0] wb_src,
  output logic idle,
  output logic err
);
  logic [IW-1:0] ptr_q, ptr_d, gnt_id, idx;
  logic gnt_any, xfer, live, accept;
  logic [GW-1:0] guard_q;
  logic [31:0] fu_adata_q, fu_bdata_q, wb_data_q;
  logic [AW-1:0] fu_address_q, wb_addr_q;
  logic fu_flag_q, wb_valid_q, err_q;
  logic [IW-1:0] wb_src_q;
  logic [LAT:0] own_v_q;
  logic [IW-1:0] own_id_q [LAT+1];
  logic [AW-1:0] own_addr_q [LAT+1];
  always_comb begin
    gnt_any = 1'b0;
    gnt_id = '0;
    idx = '0;
    // descending scan: the last hit is the nearest valid requester at or after the pointer
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr_q) + k) % NREQ);
      if (req.req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id = idx;
      end
    end
  end
  assign live = guard_q == '0;
  assign xfer = gnt_any & live & ~req.hold & ~rst;
  assign accept = fu_flag_out & live;
  assign ptr_d = gnt_id == IW'(NREQ - 1) ? '0 : gnt_id + 1'b1;
  assign req.req_ready = NREQ'(xfer) << gnt_id;
  assign fu_adata = fu_adata_q;
  assign fu_bdata = fu_bdata_q;
  assign fu_flag = fu_flag_q;
  assign fu_address = fu_address_q;
  assign wb_valid = wb_valid_q;
  assign wb_addr = wb_addr_q;
  assign wb_data = wb_data_q;
  assign wb_src = wb_src_q;
  assign err = err_q;
  assign idle = rst | (live & ~fu_flag_q & ~|own_v_q & ~wb_valid_q);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ptr_q <= '0;
      guard_q <= GW'(LAT);
      fu_adata_q <= '0;
      fu_bdata_q <= '0;
      fu_address_q <= '0;
      fu_flag_q <= 1'b0;
      own_v_q <= '0;
      for (int i = 0; i <= LAT; i++) begin
        own_id_q[i] <= '0;
        own_addr_q[i] <= '0;
      end
      wb_valid_q <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
      wb_src_q <= '0;
      err_q <= 1'b0;
    end else begin
      // the unit is never reset, so its output is ignored until stale flags have drained
      guard_q <= guard_q - GW'(guard_q != '0);
      fu_flag_q <= xfer;
      if (xfer) begin
        ptr_q <= ptr_d;
        fu_adata_q <= 32'(req.req_adata >> (32 * gnt_id));
        fu_bdata_q <= 32'(req.req_bdata >> (32 * gnt_id));
        fu_address_q <= AW'(req.req_addr >> (AW * gnt_id));
      end
      own_v_q <= {own_v_q[LAT-1:0], xfer};
      own_id_q[0] <= gnt_id;
      own_addr_q[0] <= AW'(req.req_addr >> (AW * gnt_id));
      for (int i = 1; i <= LAT; i++) begin
        own_id_q[i] <= own_id_q[i-1];
        own_addr_q[i] <= own_addr_q[i-1];
      end
      wb_valid_q <= accept;
      if (accept) begin
        wb_addr_q <= fu_address_out;
        wb_data_q <= fu_result;
        wb_src_q <= own_id_q[LAT-1];
      end
      err_q <= err_q | (live & ((fu_flag_out ^ own_v_q[LAT-1]) |
               (fu_flag_out & (fu_address_out != own_addr_q[LAT-1]))));
    end
endmodule

// File: tb/tb_fpu_addsub_arbiter.sv
// tb_fpu_addsub_arbiter: directed and random issue traffic against a transaction-level model of the arbiter
module tb_fpu_addsub_arbiter;
  localparam int NREQ = 2, LAT = 3, AW = 5;
  typedef struct {int due; int id; logic [AW-1:0] addr; logic [31:0] data; bit bad;} wb_t;
  logic clk = 0, rst = 0;
  always #5 clk = ~clk;
  fpu_addsub_arbiter_if #(.NREQ(NREQ), .AW(AW)) bus ();
  logic [31:0] fu_adata, fu_bdata, fu_result, wb_data;
  logic fu_flag, fu_flag_out, wb_valid, idle, err;
  logic [AW-1:0] fu_address, fu_address_out, wb_addr;
  logic [0:0] wb_src;
  fpu_addsub_arbiter #(.NREQ(NREQ), .LAT(LAT), .AW(AW)) dut (
    .clk(clk), .rst(rst), .req(bus),
    .fu_adata(fu_adata), .fu_bdata(fu_bdata), .fu_flag(fu_flag), .fu_address(fu_address),
    .fu_flag_out(fu_flag_out), .fu_address_out(fu_address_out), .fu_result(fu_result),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_src(wb_src),
    .idle(idle), .err(err)
  );
  function automatic real s2r(logic [31:0] s);
    return $bitstoreal({s[31], 11'(int'(s[30:23]) + 896), s[22:0], 29'd0});
  endfunction
  function automatic logic [31:0] r2s(real r);
    logic [63:0] d;
    d = $realtobits(r);
    return r == 0.0 ? 32'd0 : {d[63], 8'(int'(d[62:52]) - 896), d[51:29]};
  endfunction
  function automatic logic [31:0] rf();
    return {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
  endfunction
  // unit model: subtracts, not reset, powers up with stale flags in flight
  bit inject = 0;
  logic [LAT-2:0] u_flag = '1;
  logic [AW-1:0] u_addr [LAT-1];
  logic [31:0] u_res [LAT-1];
  always @(posedge clk) begin
    u_flag <= (LAT-1)'({u_flag, fu_flag});
    u_addr[0] <= fu_address;
    u_res[0] <= r2s(s2r(fu_adata) - s2r(fu_bdata));
    for (int i = 1; i < LAT - 1; i++) begin
      u_addr[i] <= u_addr[i-1];
      u_res[i] <= u_res[i-1];
    end
  end
  assign fu_flag_out = u_flag[LAT-2];
  assign fu_address_out = (inject && u_addr[LAT-2] == AW'(6)) ? AW'(7) : u_addr[LAT-2];
  assign fu_result = u_res[LAT-2];
  wb_t pend[$];
  int n_vec = 0, n_err = 0, cy = 0, p_m = 0, guard_m = LAT, last_x = -100, ws_m = 0;
  bit err_m = 0, fl_m = 0, wv_m = 0, hold_v = 0;
  logic [31:0] fa_m = 0, fb_m = 0, wd_m = 0;
  logic [AW-1:0] fad_m = 0, wa_m = 0;
  logic [NREQ-1:0] v = '0, gnt_m = '0;
  logic [31:0] a [NREQ];
  logic [31:0] b [NREQ];
  logic [AW-1:0] ad [NREQ];
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cy, got, exp);
    end
  endtask
  task automatic fresh(int i);
    a[i] = rf();
    b[i] = rf();
    ad[i] = AW'($urandom_range(0, 5));
  endtask
  task automatic cyc();
    int w;
    logic [NREQ-1:0] er;
    wb_t e;
    bus.req_valid = v;
    bus.hold = hold_v;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_adata[32*i +: 32] = a[i];
      bus.req_bdata[32*i +: 32] = b[i];
      bus.req_addr[AW*i +: AW] = ad[i];
    end
    #2;
    if (rst) begin
      pend.delete();
      err_m = 0; fl_m = 0; guard_m = LAT; p_m = 0; last_x = -100;
      fa_m = 0; fb_m = 0; fad_m = 0; wa_m = 0; wd_m = 0; ws_m = 0;
    end
    w = -1;
    if (!rst && !hold_v && guard_m == 0)
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && v[(p_m + k) % NREQ]) w = (p_m + k) % NREQ;
    er = w < 0 ? '0 : NREQ'(1) << w;
    gnt_m = er;
    wv_m = pend.size() > 0 && pend[0].due == cy;
    if (wv_m) begin
      e = pend.pop_front();
      wa_m = e.addr; wd_m = e.data; ws_m = e.id;
      err_m |= e.bad;
    end
    chk("ready", bus.req_ready, er);
    chk("fu_flag", fu_flag, fl_m);
    chk("fu_adata", fu_adata, fa_m);
    chk("fu_bdata", fu_bdata, fb_m);
    chk("fu_address", fu_address, fad_m);
    chk("wb_valid", wb_valid, wv_m);
    chk("wb_addr", wb_addr, wa_m);
    chk("wb_data", wb_data, wd_m);
    chk("wb_src", wb_src, 64'(ws_m));
    chk("err", err, err_m);
    chk("idle", idle, rst || (guard_m == 0 && cy - last_x > LAT + 1));
    @(posedge clk);
    if (w >= 0) begin
      pend.push_back('{cy + LAT + 1, w, (inject && ad[w] == 6) ? AW'(7) : ad[w],
                       r2s(s2r(a[w]) - s2r(b[w])), inject && ad[w] == 6});
      p_m = (w + 1) % NREQ;
      last_x = cy;
      fa_m = a[w]; fb_m = b[w]; fad_m = ad[w];
    end
    fl_m = w >= 0;
    if (!rst && guard_m > 0) guard_m--;
    cy++;
    #1;
  endtask
  initial begin
    for (int i = 0; i < NREQ; i++) fresh(i);
    #1 rst = 1;
    cyc(); cyc();
    rst = 0;
    // single op held through the post-reset guard window
    v = 2'b01; a[0] = 32'h40400000; b[0] = 32'h3F800000; ad[0] = 5;
    repeat (LAT) cyc();
    cyc();
    v = '0;
    repeat (3) cyc();
    chk("single_wb", {wb_valid, wb_src, wb_addr, wb_data}, {1'b1, 1'b0, 5'd5, 32'h40000000});
    repeat (3) cyc();
    // pointer now 1: lone req0 wins, then req1 first under contention, then strict alternation
    fresh(0); v = 2'b01; cyc();
    fresh(0); v = 2'b11;
    repeat (7) begin
      cyc();
      for (int i = 0; i < NREQ; i++) if (gnt_m[i]) fresh(i);
    end
    hold_v = 1;
    repeat (LAT + 2) cyc();
    chk("hold_idle", idle, 1'b1);
    hold_v = 0;
    cyc();
    v = '0;
    repeat (6) cyc();
    // reset two cycles after a transfer, while the unit still carries it
    fresh(0); v = 2'b01; cyc();
    v = '0; cyc();
    rst = 1; cyc();
    rst = 0; v = 2'b01;
    repeat (LAT) cyc();
    cyc();
    v = '0;
    repeat (6) cyc();
    // unit returns tag 7 for an op issued with tag 6
    inject = 1; fresh(0); ad[0] = 6; v = 2'b01; cyc();
    v = '0;
    repeat (3) cyc();
    chk("err_wb", {wb_valid, wb_addr, err}, {1'b1, 5'd7, 1'b1});
    repeat (4) cyc();
    chk("err_sticky", err, 1'b1);
    inject = 0;
    rst = 1; cyc();
    rst = 0;
    repeat (LAT + 1) cyc();
    for (int n = 0; n < 500; n++) begin
      for (int i = 0; i < NREQ; i++)
        if (!v[i] || gnt_m[i]) begin
          v[i] = $urandom_range(0, 3) != 0;
          fresh(i);
        end
      hold_v = $urandom_range(0, 9) == 0;
      cyc();
    end
    v = '0; hold_v = 0;
    repeat (LAT + 4) cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
